// File: rtl/mux_n_to_1_stream.sv
// N-to-1 valid/ready stream multiplexer with fixed or round-robin selection,
// packet locking on *_last, and a single registered output slot.
module mux_n_to_1_stream #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  input  logic [N-1:0]      in_last,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [SELW-1:0]   out_src,
  input  logic              out_ready,
  output logic              dbg_lock,
  output logic [SELW-1:0]   dbg_lock_ch,
  output logic [SELW-1:0]   dbg_ptr
);

  // Handshake: a beat moves on channel k when in_valid[k] && in_ready[k];
  // the output beat moves when out_valid && out_ready. Valid never waits on ready.

  localparam int NP = 1 << SELW;

  logic            lock;
  logic [SELW-1:0] lock_ch;
  logic [SELW-1:0] ptr;
  logic            free;
  logic            grant;
  logic [SELW-1:0] g;
  logic [W-1:0]    g_data;
  logic            g_last;
  logic [NP-1:0]   valid_ext;
  logic [NP-1:0]   last_ext;
  logic [NP-1:0]   ready_ext;
  logic [SELW-1:0] ptr_next;
  int              idx;

  // Padding to a power of two keeps every select index in range, including sel >= N.
  assign valid_ext = NP'(in_valid);
  assign last_ext  = NP'(in_last);
  assign free      = !out_valid || out_ready;

  always_comb begin
    grant = 1'b0;
    g     = '0;
    idx   = 0;
    if (lock) begin
      g     = lock_ch;
      grant = valid_ext[lock_ch];
    end else if (!mode) begin
      g     = sel;
      grant = (int'(sel) < N) && valid_ext[sel];
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!grant && in_valid[idx]) begin
          grant = 1'b1;
          g     = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(g) == k) g_data = in_data[k*W +: W];
    end
  end

  assign g_last = last_ext[g];

  always_comb begin
    ready_ext = '0;
    if (!rst && free && grant) ready_ext[g] = 1'b1;
  end

  assign in_ready = ready_ext[N-1:0];
  assign ptr_next = (int'(g) == N - 1) ? '0 : g + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
      ptr       <= '0;
    end else if (free) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_last  <= g_last;
        out_src   <= g;
        if (g_last) begin
          lock <= 1'b0;
          if (mode) ptr <= ptr_next;
        end else begin
          lock    <= 1'b1;
          lock_ch <= g;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_lock    = lock;
  assign dbg_lock_ch = lock_ch;
  assign dbg_ptr     = ptr;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Randomized and directed bench for mux_n_to_1_stream, compared cycle by cycle
// against a transaction-level reference model of the grant/lock/pointer rules.
module tb_mux_n_to_1_stream;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int SELW = $clog2(N);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_last;
  logic [N-1:0]      in_ready;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_last;
  logic [SELW-1:0]   out_src;
  logic              out_ready;
  logic              dbg_lock;
  logic [SELW-1:0]   dbg_lock_ch;
  logic [SELW-1:0]   dbg_ptr;

  mux_n_to_1_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready),
    .dbg_lock(dbg_lock), .dbg_lock_ch(dbg_lock_ch), .dbg_ptr(dbg_ptr)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_lock = 0;
  int          m_lock_ch = 0;
  int          m_ptr = 0;
  bit          m_ov = 0;
  bit          m_ol = 0;
  logic [W-1:0] m_od = '0;
  int          m_os = 0;

  // sources of beats consumed downstream, as seen on the DUT outputs
  int src_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int ch, input logic [W-1:0] v);
    logic [N*W-1:0] d;
    d = '0;
    d[ch*W +: W] = v;
    return d;
  endfunction

  // driver: one cycle of stimulus, with output and in_ready checks against the model
  task automatic step(input logic r, input logic md, input logic [SELW-1:0] s,
                      input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*W-1:0] d, input logic ordy);
    int g;
    bit gnt;
    bit fr;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_last", 32'(out_last), 32'(m_ol));
    check("out_src", 32'(out_src), 32'(m_os));
    check("ptr", 32'(dbg_ptr), 32'(m_ptr));
    check("lock", 32'(dbg_lock), 32'(m_lock));
    if (m_lock) check("lock_ch", 32'(dbg_lock_ch), 32'(m_lock_ch));
    rst = r; mode = md; sel = s; in_valid = v; in_last = l; in_data = d; out_ready = ordy;
    #1;
    fr  = !m_ov || ordy;
    gnt = 0;
    g   = 0;
    if (m_lock) begin
      g = m_lock_ch; gnt = v[g];
    end else if (!md) begin
      if (int'(s) < N) begin g = int'(s); gnt = v[g]; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!gnt && v[(m_ptr + i) % N]) begin g = (m_ptr + i) % N; gnt = 1; end
      end
    end
    exp_rdy = (!r && fr && gnt) ? N'(1 << g) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!r && out_valid && ordy) src_log.push_back(int'(out_src));
    if (r) begin
      m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_lock = 0; m_lock_ch = 0; m_ptr = 0;
    end else if (fr) begin
      if (gnt) begin
        m_ov = 1; m_od = d[g*W +: W]; m_ol = l[g]; m_os = g;
        if (l[g]) begin
          m_lock = 0;
          if (md) m_ptr = (g + 1) % N;
        end else begin
          m_lock = 1; m_lock_ch = g;
        end
      end else begin
        m_ov = 0;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, mode, sel, '0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic           md;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset with every channel valid: no ready, outputs cleared
    step(1'b1, 1'b0, '0, '1, '1, '1, 1'b1);
    step(1'b1, 1'b1, '0, '1, '1, '1, 1'b1);
    idle();

    // fixed select of channel 2, three-beat packet
    src_log.delete();
    step(1'b0, 1'b0, SELW'(2), 5'b00100, 5'b00000, pack(2, 8'h11), 1'b1);
    step(1'b0, 1'b0, SELW'(2), 5'b00100, 5'b00000, pack(2, 8'h22), 1'b1);
    step(1'b0, 1'b0, SELW'(2), 5'b00100, 5'b00100, pack(2, 8'h33), 1'b1);
    idle();
    check("fixed_count", 32'(src_log.size()), 32'd3);
    foreach (src_log[i]) check("fixed_src", 32'(src_log[i]), 32'd2);

    // round-robin, every channel streaming single-beat packets
    src_log.delete();
    for (int i = 0; i < 10; i++) begin
      d = (N*W)'({$urandom, $urandom});
      step(1'b0, 1'b1, '0, '1, '1, d, 1'b1);
    end
    idle();
    check("rr_count", 32'(src_log.size()), 32'd10);
    foreach (src_log[i]) check("rr_src", 32'(src_log[i]), 32'(i % N));

    // packet lock on channel 1 while ch0 is valid and mode/sel change
    src_log.delete();
    step(1'b0, 1'b0, SELW'(1), 5'b00011, 5'b00001, pack(1, 8'hB1) | pack(0, 8'hC0), 1'b1);
    step(1'b0, 1'b1, SELW'(0), 5'b00011, 5'b00001, pack(1, 8'hB2) | pack(0, 8'hC0), 1'b1);
    step(1'b0, 1'b1, SELW'(0), 5'b00011, 5'b00011, pack(1, 8'hB3) | pack(0, 8'hC0), 1'b1);
    step(1'b0, 1'b1, SELW'(0), 5'b00001, 5'b00001, pack(0, 8'hC0), 1'b1);
    idle();
    check("lock_count", 32'(src_log.size()), 32'd4);
    if (src_log.size() == 4) begin
      check("lock_seq0", 32'(src_log[0]), 32'd1);
      check("lock_seq1", 32'(src_log[1]), 32'd1);
      check("lock_seq2", 32'(src_log[2]), 32'd1);
      check("lock_seq3", 32'(src_log[3]), 32'd0);
    end

    // backpressure holding 0xA5, then release accepts the next beat at once
    step(1'b0, 1'b0, SELW'(3), 5'b01000, 5'b01000, pack(3, 8'hA5), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, SELW'(3), 5'b01000, 5'b01000, pack(3, 8'h5A), 1'b0);
      check("bp_data", 32'(out_data), 32'h0000_00A5);
    end
    step(1'b0, 1'b0, SELW'(3), 5'b01000, 5'b01000, pack(3, 8'h5A), 1'b1);
    check("bp_release", 32'(in_ready), 32'h0000_0008);
    idle();

    // out-of-range select never grants
    for (int s = N; s < (1 << SELW); s++) step(1'b0, 1'b0, SELW'(s), '1, '1, '1, 1'b1);
    idle();

    // reset during beat 2 of 3 clears the lock and the pointer
    step(1'b0, 1'b1, '0, 5'b01000, 5'b00000, pack(3, 8'h01), 1'b1);
    step(1'b1, 1'b1, '0, 5'b01000, 5'b00000, pack(3, 8'h02), 1'b1);
    src_log.delete();
    step(1'b0, 1'b1, '0, '1, '1, (N*W)'({$urandom, $urandom}), 1'b1);
    idle();
    check("post_rst_src", (src_log.size() > 0) ? 32'(src_log[0]) : 32'hFFFF_FFFF, 32'd0);

    // randomized traffic
    md = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      v = N'($urandom);
      l = N'($urandom) & N'($urandom);
      d = (N*W)'({$urandom, $urandom});
      step(($urandom_range(0, 99) == 0), md, SELW'($urandom_range(0, (1 << SELW) - 1)),
           v, l, d, ($urandom_range(0, 3) != 0));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
